// File: rtl/aer_pixel_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : aer_pixel_arbiter
//  Purpose  : 2-row x 2-column x 2-polarity address-event arbiter. Latches
//             pixel event pulses, picks a row round-robin and then a
//             column/polarity by fixed priority. It sends one event at a time
//             downstream, framed by req.
//  Ports    : clk   - system clock (rising edge)
//             rst_n - synchronous active-low reset
//             E     - pixel event pulses, index = row*4 + col*2 + pol
//             ack   - downstream acknowledge (ACK_HANDSHAKE_EN builds only)
//             req   - event-valid strobe
//             ON    - polarity of the event being sent (1 = ON)
//             CA    - one-hot column grant
//             COL   - column requests within the granted row
//             CRON  - pending bits of the granted row {c0on,c0off,c1on,c1off}
//             R     - row requests
//             RA    - one-hot row grant
//             Rp    - one-hot round-robin row priority pointer
//             RR    - one-cycle row-done pulse
//  Options  : `define ACK_HANDSHAKE_EN selects the 4-phase req/ack handshake
//             in place of the fixed HOLD_CYCLES req window.
//  Revision : 1.0 - initial release
// ============================================================================
module aer_pixel_arbiter #(
  parameter int unsigned HOLD_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [0:7] E,
`ifdef ACK_HANDSHAKE_EN
  input  logic       ack,
`endif
  output logic       req,
  output logic       ON,
  output logic [0:1] CA,
  output logic [0:1] COL,
  output logic [0:3] CRON,
  output logic [0:1] R,
  output logic [0:1] RA,
  output logic [0:1] Rp,
  output logic [0:1] RR
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ROW  = 3'd1,
    S_COL  = 3'd2,
    S_SEND = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t     state, state_nxt;
  logic [0:7] e_d;
  logic [0:7] pend;
  logic [0:7] rise;
  logic [0:7] clr_mask;
  logic [0:3] row_bits;
  logic [0:1] ra_nxt, ca_nxt, rp_nxt;
  logic       on_nxt;
  logic       rearm, rearm_nxt;
  logic [2:0] srv_idx;
`ifndef ACK_HANDSHAKE_EN
  logic [7:0] cnt, cnt_nxt;
`endif

  assign rise = E & ~e_d;

  assign R[0] = |pend[0:3];
  assign R[1] = |pend[4:7];

  always_comb begin
    row_bits = 4'b0000;
    if (RA[0])      row_bits = pend[0:3];
    else if (RA[1]) row_bits = pend[4:7];
  end

  assign CRON   = row_bits;
  assign COL[0] = row_bits[0] | row_bits[1];
  assign COL[1] = row_bits[2] | row_bits[3];

  // Index of the pixel in flight; valid once CA/ON are registered (COL..DONE).
  assign srv_idx = {RA[1], CA[1], ~ON};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
      e_d   <= '0;
      pend  <= '0;
      RA    <= '0;
      CA    <= '0;
      ON    <= 1'b0;
      Rp    <= 2'b10;
      rearm <= 1'b0;
`ifndef ACK_HANDSHAKE_EN
      cnt   <= '0;
`endif
    end else begin
      state <= state_nxt;
      e_d   <= E;
      // A new rising edge wins over the clear of the served bit.
      pend  <= (pend & ~clr_mask) | rise;
      RA    <= ra_nxt;
      CA    <= ca_nxt;
      ON    <= on_nxt;
      Rp    <= rp_nxt;
      rearm <= rearm_nxt;
`ifndef ACK_HANDSHAKE_EN
      cnt   <= cnt_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt = state;
    ra_nxt    = RA;
    ca_nxt    = CA;
    on_nxt    = ON;
    rp_nxt    = Rp;
    rearm_nxt = rearm;
    clr_mask  = '0;
    req       = 1'b0;
    RR        = 2'b00;
`ifndef ACK_HANDSHAKE_EN
    cnt_nxt   = cnt;
`endif

    case (state)
      S_IDLE: begin
        if (|R) begin
          state_nxt = S_ROW;
          if (R[0] && R[1]) ra_nxt = Rp;
          else if (R[0])    ra_nxt = 2'b10;
          else              ra_nxt = 2'b01;
        end
      end

      S_ROW: begin
        state_nxt = S_COL;
        rearm_nxt = 1'b0;
        if (row_bits[0]) begin
          ca_nxt = 2'b10; on_nxt = 1'b1;
        end else if (row_bits[1]) begin
          ca_nxt = 2'b10; on_nxt = 1'b0;
        end else if (row_bits[2]) begin
          ca_nxt = 2'b01; on_nxt = 1'b1;
        end else if (row_bits[3]) begin
          ca_nxt = 2'b01; on_nxt = 1'b0;
        end else begin
          // Defensive: the granted row cannot empty before DONE.
          state_nxt = S_IDLE;
          ra_nxt    = 2'b00;
        end
      end

      S_COL: begin
        // A fresh edge on the in-flight pixel must survive the DONE clear.
        rearm_nxt = rearm | rise[srv_idx];
`ifndef ACK_HANDSHAKE_EN
        cnt_nxt   = 8'(HOLD_CYCLES);
`endif
        state_nxt = S_SEND;
      end

      S_SEND: begin
        req       = 1'b1;
        rearm_nxt = rearm | rise[srv_idx];
`ifdef ACK_HANDSHAKE_EN
        if (ack) state_nxt = S_DONE;
`else
        cnt_nxt = cnt - 8'd1;
        if (cnt <= 8'd1) state_nxt = S_DONE;
`endif
      end

      S_DONE: begin
        RR        = RA;
        rearm_nxt = rearm | rise[srv_idx];
`ifdef ACK_HANDSHAKE_EN
        if (!ack) begin
`else
        begin
`endif
          state_nxt = S_IDLE;
          ra_nxt    = 2'b00;
          ca_nxt    = 2'b00;
          on_nxt    = 1'b0;
          rp_nxt    = {RA[1], RA[0]};
          rearm_nxt = 1'b0;
          if (!rearm) clr_mask[srv_idx] = 1'b1;
        end
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_aer_pixel_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_aer_pixel_arbiter
//  Purpose  : Self-checking bench for aer_pixel_arbiter (fixed-hold build).
//             A timeline reference model predicts every output each cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_aer_pixel_arbiter;

  localparam int H = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [0:7] E;
  logic       req, ON;
  logic [0:1] CA, COL, R, RA, Rp, RR;
  logic [0:3] CRON;

  always #5 clk = ~clk;

  aer_pixel_arbiter #(.HOLD_CYCLES(H)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .E    (E),
    .req  (req),
    .ON   (ON),
    .CA   (CA),
    .COL  (COL),
    .CRON (CRON),
    .R    (R),
    .RA   (RA),
    .Rp   (Rp),
    .RR   (RR)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check_value(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // phase counts cycles since the grant: 0 idle, 1 row grant, 2 column
  // grant, 3..H+2 req window, H+3 row-done.
  bit [0:7] m_pend;
  bit [0:7] m_ed;
  int       m_phase;
  int       m_row;
  int       m_pix;
  bit       m_keep;
  int       m_rp;

  function automatic logic [0:1] onehot2(input int k);
    logic [0:1] v;
    v = 2'b00;
    v[k] = 1'b1;
    return v;
  endfunction

  task automatic model_step(input logic [0:7] e, input logic rn);
    bit [0:7] rise;
    bit       r0, r1;
    if (!rn) begin
      m_pend = '0; m_ed = '0; m_phase = 0; m_keep = 0; m_rp = 0;
      m_row = 0; m_pix = 0;
      return;
    end
    rise = e & ~m_ed;
    r0 = |m_pend[0:3];
    r1 = |m_pend[4:7];
    if (m_phase == 0) begin
      if (r0 || r1) begin
        m_row   = (r0 && r1) ? m_rp : (r0 ? 0 : 1);
        m_phase = 1;
      end
    end else if (m_phase == 1) begin
      m_pix = -1;
      for (int j = 3; j >= 0; j--)
        if (m_pend[m_row*4 + j]) m_pix = m_row*4 + j;
      m_keep  = 0;
      m_phase = 2;
    end else if (m_phase < H + 3) begin
      m_keep  = m_keep | rise[m_pix];
      m_phase = m_phase + 1;
    end else begin
      m_keep = m_keep | rise[m_pix];
      if (!m_keep) m_pend[m_pix] = 1'b0;
      m_rp    = 1 - m_row;
      m_phase = 0;
      m_keep  = 0;
    end
    m_pend = m_pend | rise;
    m_ed   = e;
  endtask

  task automatic check_outputs();
    logic [0:1] x_r, x_ra, x_ca, x_col, x_rr;
    logic [0:3] x_cron;
    logic       x_on, x_req;
    x_r[0] = |m_pend[0:3];
    x_r[1] = |m_pend[4:7];
    x_ra = 2'b00; x_cron = 4'b0000; x_ca = 2'b00; x_on = 1'b0; x_rr = 2'b00;
    if (m_phase >= 1) begin
      x_ra = onehot2(m_row);
      for (int j = 0; j < 4; j++) x_cron[j] = m_pend[m_row*4 + j];
    end
    if (m_phase >= 2) begin
      x_ca = onehot2((m_pix / 2) % 2);
      x_on = ~m_pix[0];
    end
    x_col[0] = x_cron[0] | x_cron[1];
    x_col[1] = x_cron[2] | x_cron[3];
    x_req = (m_phase >= 3) && (m_phase <= H + 2);
    if (m_phase == H + 3) x_rr = onehot2(m_row);
    check_value("req",  req,  x_req);
    check_value("ON",   ON,   x_on);
    check_value("CA",   CA,   x_ca);
    check_value("RA",   RA,   x_ra);
    check_value("RR",   RR,   x_rr);
    check_value("Rp",   Rp,   onehot2(m_rp));
    check_value("R",    R,    x_r);
    check_value("COL",  COL,  x_col);
    check_value("CRON", CRON, x_cron);
  endtask

  // ---------------- event log ----------------
  logic [4:0] ev_q[$];
  int         tcount = 0;
  int         first_req_tick = -1;
  int         req_hi = 0;
  logic       prev_req = 1'b0;

  task automatic tick(input logic [0:7] e, input logic rn);
    E = e;
    rst_n = rn;
    model_step(e, rn);
    @(posedge clk);
    @(negedge clk);
    tcount++;
    check_outputs();
    if (req && !prev_req) begin
      ev_q.push_back({RA, CA, ON});
      if (first_req_tick < 0) first_req_tick = tcount;
    end
    if (req) req_hi++;
    prev_req = req;
  endtask

  task automatic clear_log();
    ev_q.delete();
    first_req_tick = -1;
    req_hi = 0;
  endtask

  task automatic do_reset();
    tick(8'hA5, 1'b0);
    tick(8'h5A, 1'b0);
    tick(8'h00, 1'b1);
  endtask

  initial begin
    int         t_edge;
    bit         seen;
    logic [0:7] nxt;
    logic [4:0] exp_seq[4];

    E = '0;
    rst_n = 1'b0;
    @(negedge clk);

    // Reset with E toggling, then quiet: no event may appear.
    do_reset();
    check_value("reset_Rp", Rp, 2'b10);
    clear_log();
    repeat (20) tick(8'h00, 1'b1);
    check_value("reset_no_event", ev_q.size(), 0);

    // Single event on E[2]: row0, c1, ON.
    clear_log();
    tick(8'b0010_0000, 1'b1);
    t_edge = tcount;
    tick(8'h00, 1'b1);
    repeat (15) tick(8'h00, 1'b1);
    check_value("single_count", ev_q.size(), 1);
    if (ev_q.size() == 1) check_value("single_grant", ev_q[0], 5'b10_01_1);
    check_value("single_latency", first_req_tick - t_edge, 3);
    check_value("single_req_len", req_hi, H);

    // Simultaneous E0, E3, E4, E7 after reset (Rp back on row 0).
    do_reset();
    clear_log();
    tick(8'b1001_1001, 1'b1);
    tick(8'h00, 1'b1);
    repeat (4 * (H + 4) + 10) tick(8'h00, 1'b1);
    exp_seq[0] = 5'b10_10_1;
    exp_seq[1] = 5'b01_10_1;
    exp_seq[2] = 5'b10_01_0;
    exp_seq[3] = 5'b01_01_0;
    check_value("simul_count", ev_q.size(), 4);
    for (int k = 0; k < 4; k++)
      if (k < ev_q.size()) check_value("simul_order", ev_q[k], exp_seq[k]);

    // Level held high on E[1]: a single event only.
    clear_log();
    repeat (1000) tick(8'b0100_0000, 1'b1);
    repeat (10) tick(8'h00, 1'b1);
    check_value("level_count", ev_q.size(), 1);
    if (ev_q.size() == 1) check_value("level_grant", ev_q[0], 5'b10_10_0);

    // Retrigger E[5] while its req window is open.
    clear_log();
    tick(8'b0000_0100, 1'b1);
    tick(8'h00, 1'b1);
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      if (req) seen = 1'b1;
      else tick(8'h00, 1'b1);
    end
    check_value("retrig_wait", seen, 1'b1);
    tick(8'b0000_0100, 1'b1);
    tick(8'h00, 1'b1);
    repeat (3 * (H + 4)) tick(8'h00, 1'b1);
    check_value("retrig_count", ev_q.size(), 2);
    for (int k = 0; k < 2; k++)
      if (k < ev_q.size()) check_value("retrig_grant", ev_q[k], 5'b01_10_0);

    // Randomized traffic with occasional mid-transfer resets.
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < 8; i++)
        nxt[i] = E[i] ^ ($urandom_range(0, 5) == 0);
      tick(nxt, ($urandom_range(0, 499) != 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
